// File: rtl/priority_encoder_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : priority_encoder_pipe
//  Purpose  : Registered priority encoder with valid/ready handshakes on both
//             sides. Each transaction selects either fixed MSB-first priority
//             or round-robin priority, which uses a rotating pointer. All-zero
//             inputs are reported through a flag and a saturating counter.
//  Ports    : clk, rst_n                 - clock, async active-low reset
//             in_valid/in_ready          - input handshake
//             data_in, mode_rr           - request vector, 1 = round-robin
//             out_valid/out_ready        - output handshake
//             out_idx, out_onehot,
//             out_found                  - registered encode result
//             empty_cnt                  - saturating count of empty inputs
//  Revision : 1.0  initial release
// ============================================================================
module priority_encoder_pipe #(
   parameter int  WIDTH = 8,
   parameter int  CNT_W = 16,
   localparam int IDX_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] data_in,
   input  logic             mode_rr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic [WIDTH-1:0] out_onehot,
   output logic             out_found,
   output logic [CNT_W-1:0] empty_cnt
);

   localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(WIDTH - 1);

   logic             out_valid_q,  out_valid_d;
   logic [IDX_W-1:0] out_idx_q,    out_idx_d;
   logic [WIDTH-1:0] out_onehot_q, out_onehot_d;
   logic             out_found_q,  out_found_d;
   logic [CNT_W-1:0] empty_cnt_q,  empty_cnt_d;
   logic [IDX_W-1:0] ptr_q,        ptr_d;

   logic             accept;
   logic [IDX_W-1:0] eff_ptr;
   logic [IDX_W:0]   rot_sh;
   logic [WIDTH-1:0] rot;
   logic             srch_found;
   logic [IDX_W-1:0] rot_idx;
   logic [IDX_W:0]   unrot_sum;
   logic [IDX_W-1:0] srch_idx;
   logic [WIDTH-1:0] srch_onehot;

   assign in_ready = !out_valid_q | out_ready;
   assign accept   = in_valid & in_ready;

   // Search: rotate so the highest-priority position lands on the MSB,
   // encode MSB-first, then map the rotated index back.
   // rot[k] = data_in[(eff_ptr + 1 + k) mod WIDTH], hence rot[WIDTH-1] is
   // data_in[eff_ptr]. Fixed mode uses eff_ptr = WIDTH-1, i.e. no rotation.
   always_comb begin
      eff_ptr    = mode_rr ? ptr_q : PTR_RESET;
      rot_sh     = {1'b0, eff_ptr} + (IDX_W+1)'(1);
      rot        = WIDTH'({data_in, data_in} >> rot_sh);

      srch_found = 1'b0;
      rot_idx    = '0;
      // Ascending scan, last hit wins: that is the highest set rotated bit.
      for (int k = 0; k < WIDTH; k++) begin
         if (rot[k]) begin
            srch_found = 1'b1;
            rot_idx    = IDX_W'(k);
         end
      end

      unrot_sum = {1'b0, eff_ptr} + {1'b0, rot_idx} + (IDX_W+1)'(1);
      if (unrot_sum >= (IDX_W+1)'(WIDTH)) begin
         unrot_sum = unrot_sum - (IDX_W+1)'(WIDTH);
      end

      srch_idx    = srch_found ? unrot_sum[IDX_W-1:0] : '0;
      srch_onehot = srch_found ? (WIDTH'(1) << srch_idx) : '0;
   end

   // Next-state: load on accept, otherwise drop valid once the result is taken.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_idx_d    = out_idx_q;
      out_onehot_d = out_onehot_q;
      out_found_d  = out_found_q;
      empty_cnt_d  = empty_cnt_q;
      ptr_d        = ptr_q;

      if (accept) begin
         out_valid_d  = 1'b1;
         out_idx_d    = srch_idx;
         out_onehot_d = srch_onehot;
         out_found_d  = srch_found;
         if (!srch_found) begin
            if (empty_cnt_q != {CNT_W{1'b1}}) begin
               empty_cnt_d = empty_cnt_q + CNT_W'(1);
            end
         end else if (mode_rr) begin
            // Winner drops to lowest priority for the next round-robin search.
            ptr_d = (srch_idx == '0) ? PTR_RESET : (srch_idx - IDX_W'(1));
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_idx_q    <= '0;
         out_onehot_q <= '0;
         out_found_q  <= 1'b0;
         empty_cnt_q  <= '0;
         ptr_q        <= PTR_RESET;
      end else begin
         out_valid_q  <= out_valid_d;
         out_idx_q    <= out_idx_d;
         out_onehot_q <= out_onehot_d;
         out_found_q  <= out_found_d;
         empty_cnt_q  <= empty_cnt_d;
         ptr_q        <= ptr_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_idx    = out_idx_q;
   assign out_onehot = out_onehot_q;
   assign out_found  = out_found_q;
   assign empty_cnt  = empty_cnt_q;

endmodule
`default_nettype wire
